// File: rtl/cache_page_table.sv
// rtl/cache_page_table.sv - page-granular cache tag table with flush/load replacement FSM
// Tracks which virtual pages live in which SRAM page slot and drives the QSPI fill engine on a miss.
module cache_page_table #(
    parameter int ADDRESS_SIZE            = 24,
    parameter int PAGE_INDEX_ADDRESS_SIZE = 3,
    parameter int PAGE_DATA_ADDRESS_SIZE  = 5,
    localparam int PAGE_COUNT               = 1 << PAGE_INDEX_ADDRESS_SIZE,
    localparam int PAGE_NUMBER_ADDRESS_SIZE = ADDRESS_SIZE - PAGE_DATA_ADDRESS_SIZE - 2
) (
    input  logic                                                      wb_clk_i,
    input  logic                                                      wb_rst_i,
    input  logic                                                      enable,
    input  logic                                                      writeEnable,
    input  logic                                                      invalidateAll,
    input  logic                                                      busEnable,
    input  logic                                                      busWriteEnable,
    input  logic [ADDRESS_SIZE-1:0]                                   busVirtualAddress,
    output logic [PAGE_INDEX_ADDRESS_SIZE+PAGE_DATA_ADDRESS_SIZE-1:0] busPhysicalAddress,
    output logic                                                      busBusy,
    output logic                                                      busError,
    output logic                                                      fill_request,
    output logic                                                      fill_write,
    output logic [PAGE_NUMBER_ADDRESS_SIZE-1:0]                       fill_pageNumber,
    output logic [PAGE_INDEX_ADDRESS_SIZE-1:0]                        fill_pageIndex,
    input  logic                                                      fill_done,
    input  logic                                                      fill_error,
    output logic [PAGE_COUNT-1:0]                                     pageValid,
    output logic [PAGE_COUNT-1:0]                                     pageDirty
);
    localparam int IW = PAGE_INDEX_ADDRESS_SIZE;
    localparam int DW = PAGE_DATA_ADDRESS_SIZE;
    localparam int NW = PAGE_NUMBER_ADDRESS_SIZE;

    typedef enum logic [1:0] {IDLE, FLUSH, LOAD} state_t;

    state_t          state;
    state_t          next_state;
    logic [NW-1:0]   tags [PAGE_COUNT];
    logic [PAGE_COUNT-1:0] valid;
    logic [PAGE_COUNT-1:0] dirty;
    logic [IW-1:0]   replace_ptr;
    logic [IW-1:0]   victim;
    logic [IW-1:0]   victim_sel;
    logic [IW-1:0]   target_victim;
    logic [IW-1:0]   hit_index;
    logic [IW-1:0]   invalid_index;
    logic [NW-1:0]   miss_page;
    logic [NW-1:0]   page_number;
    logic [NW-1:0]   target_page;
    logic [DW-1:0]   word_offset;
    logic            hit;
    logic            invalid_found;
    logic            miss_start;
    logic            write_hit;
    logic            error_pulse;
    logic            req_d;
    logic            write_d;
    logic [NW-1:0]   page_d;
    logic [IW-1:0]   index_d;
    logic            unused_addr_bits;

    assign word_offset      = busVirtualAddress[DW+1:2];
    assign page_number      = busVirtualAddress[ADDRESS_SIZE-1:DW+2];
    assign unused_addr_bits = ^busVirtualAddress[1:0];

    // Scan downward so the lowest matching / lowest free slot wins.
    always_comb begin
        hit           = 1'b0;
        hit_index     = '0;
        invalid_found = 1'b0;
        invalid_index = '0;
        for (int i = PAGE_COUNT - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == page_number) begin
                hit       = 1'b1;
                hit_index = IW'(i);
            end
            if (!valid[i]) begin
                invalid_found = 1'b1;
                invalid_index = IW'(i);
            end
        end
    end

    assign victim_sel         = invalid_found ? invalid_index : replace_ptr;
    assign miss_start         = (state == IDLE) && !invalidateAll && busEnable && enable && !hit;
    assign write_hit          = busEnable && busWriteEnable && hit && writeEnable;
    assign busBusy            = busEnable && enable && !hit;
    assign busError           = (busEnable && !enable)
                              || (busEnable && busWriteEnable && hit && !writeEnable)
                              || error_pulse;
    assign busPhysicalAddress = {hit_index, word_offset};
    assign pageValid          = valid;
    assign pageDirty          = dirty;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (miss_start) begin
                    next_state = dirty[victim_sel] ? FLUSH : LOAD;
                end
            end
            FLUSH: begin
                if (fill_error) begin
                    next_state = IDLE;
                end else if (fill_done) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (fill_error || fill_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Fill command is computed for the state being entered, then registered.
    assign target_victim = (state == IDLE) ? victim_sel  : victim;
    assign target_page   = (state == IDLE) ? page_number : miss_page;

    always_comb begin
        req_d   = 1'b0;
        write_d = 1'b0;
        page_d  = '0;
        index_d = '0;
        case (next_state)
            FLUSH: begin
                req_d   = 1'b1;
                write_d = 1'b1;
                page_d  = tags[target_victim];
                index_d = target_victim;
            end
            LOAD: begin
                req_d   = 1'b1;
                page_d  = target_page;
                index_d = target_victim;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fill_request    <= 1'b0;
            fill_write      <= 1'b0;
            fill_pageNumber <= '0;
            fill_pageIndex  <= '0;
        end else begin
            fill_request    <= req_d;
            fill_write      <= write_d;
            fill_pageNumber <= page_d;
            fill_pageIndex  <= index_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < PAGE_COUNT; i++) begin
                tags[i] <= '0;
            end
            valid       <= '0;
            dirty       <= '0;
            replace_ptr <= '0;
            victim      <= '0;
            miss_page   <= '0;
            error_pulse <= 1'b0;
        end else begin
            error_pulse <= (state != IDLE) && fill_error;
            if (write_hit) begin
                dirty[hit_index] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (invalidateAll) begin
                        valid       <= '0;
                        dirty       <= '0;
                        replace_ptr <= '0;
                    end else if (miss_start) begin
                        victim            <= victim_sel;
                        miss_page         <= page_number;
                        valid[victim_sel] <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!fill_error && fill_done) begin
                        dirty[victim] <= 1'b0;
                    end
                end
                LOAD: begin
                    // An errored load leaves the slot invalid and the pointer where it was.
                    if (!fill_error && fill_done) begin
                        tags[victim]  <= miss_page;
                        valid[victim] <= 1'b1;
                        dirty[victim] <= 1'b0;
                        replace_ptr   <= replace_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_page_table.sv
// tb/tb_cache_page_table.sv - directed checks plus randomized scoreboard run for cache_page_table
module tb_cache_page_table;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable, writeEnable, invalidateAll, busEnable, busWriteEnable;
    logic [23:0] busVirtualAddress;
    logic [7:0]  busPhysicalAddress;
    logic        busBusy, busError, fill_request, fill_write;
    logic [16:0] fill_pageNumber;
    logic [2:0]  fill_pageIndex;
    logic        fill_done, fill_error;
    logic [7:0]  pageValid, pageDirty;

    cache_page_table dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .writeEnable(writeEnable),
        .invalidateAll(invalidateAll), .busEnable(busEnable), .busWriteEnable(busWriteEnable),
        .busVirtualAddress(busVirtualAddress), .busPhysicalAddress(busPhysicalAddress),
        .busBusy(busBusy), .busError(busError), .fill_request(fill_request),
        .fill_write(fill_write), .fill_pageNumber(fill_pageNumber),
        .fill_pageIndex(fill_pageIndex), .fill_done(fill_done), .fill_error(fill_error),
        .pageValid(pageValid), .pageDirty(pageDirty)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard entries
    typedef struct packed {logic wr; logic [16:0] pn; logic [2:0] idx;} fill_t;
    typedef struct packed {logic chk; logic [7:0] phys; logic err; logic [7:0] valid; logic [7:0] dirty;} resp_t;
    fill_t fill_q[$];
    resp_t resp_q[$];
    bit    sb_on = 1'b0;
    bit    fill_active = 1'b0;
    fill_t fe;
    resp_t re;

    always @(negedge clk) begin
        if (sb_on) begin
            if (fill_request && !fill_active) begin
                check("fill_expected", 32'(fill_q.size() != 0), 1);
                if (fill_q.size() != 0) begin
                    fe = fill_q.pop_front();
                    check("fill_cmd", 32'({fill_write, fill_pageNumber, fill_pageIndex}), 32'(fe));
                end
                fill_active = 1'b1;
            end
            if (fill_done || fill_error) fill_active = 1'b0;
            if (busEnable && !busBusy) begin
                check("resp_expected", 32'(resp_q.size() != 0), 1);
                if (resp_q.size() != 0) begin
                    re = resp_q.pop_front();
                    if (re.chk) check("phys_addr", 32'(busPhysicalAddress), 32'(re.phys));
                    check("bus_error", 32'(busError), 32'(re.err));
                    check("page_valid", 32'(pageValid), 32'(re.valid));
                    check("page_dirty", 32'(pageDirty), 32'(re.dirty));
                end
            end
        end
    end

    // Reference model: slot table with lowest-free / round-robin replacement
    logic [16:0] tag_m [8];
    logic [7:0]  valid_m, dirty_m;
    int          ptr_m;

    task automatic model_access(input logic [23:0] a, input bit en, input bit we, input bit wen);
        logic [16:0] page;
        int          slot;
        int          v;
        page = a[23:7];
        slot = -1;
        for (int i = 0; i < 8; i++)
            if (slot < 0 && valid_m[i] && tag_m[i] == page) slot = i;
        if (!en) begin
            resp_q.push_back({1'b0, 8'h00, 1'b1, valid_m, dirty_m});
        end else begin
            if (slot < 0) begin
                v = ptr_m;
                for (int i = 0; i < 8; i++)
                    if (!valid_m[i]) begin v = i; break; end
                if (dirty_m[v]) fill_q.push_back({1'b1, tag_m[v], 3'(v)});
                fill_q.push_back({1'b0, page, 3'(v)});
                tag_m[v] = page;
                valid_m[v] = 1'b1;
                dirty_m[v] = 1'b0;
                ptr_m = (ptr_m + 1) % 8;
                slot = v;
            end
            resp_q.push_back({1'b1, 3'(slot), a[6:2], we && !wen, valid_m, dirty_m});
        end
        if (slot >= 0 && we && wen) dirty_m[slot] = 1'b1;
    endtask

    task automatic drive_access(input logic [23:0] a, input bit en, input bit we, input bit wen);
        enable = en; writeEnable = wen; busWriteEnable = we;
        busVirtualAddress = a; busEnable = 1'b1;
        #1;
        for (int n = 0; n < 60; n++) begin
            if (!busBusy) break;
            if (fill_request) begin
                repeat ($urandom_range(0, 2)) tick();
                fill_done = 1'b1;
                tick();
                fill_done = 1'b0;
            end else begin
                tick();
            end
        end
        check("access_bound", 32'(busBusy), 0);
        tick();
        busEnable = 1'b0; busWriteEnable = 1'b0; enable = 1'b1; writeEnable = 1'b1;
    endtask

    task automatic serve(input bit err, input bit done);
        for (int n = 0; n < 20 && !fill_request; n++) tick();
        check("serve_request", 32'(fill_request), 1);
        fill_error = err; fill_done = done;
        tick();
        fill_error = 1'b0; fill_done = 1'b0;
    endtask

    task automatic load_page(input logic [16:0] p);
        busVirtualAddress = {p, 7'h00}; busEnable = 1'b1; busWriteEnable = 1'b0;
        tick();
        serve(1'b0, 1'b1);
        check("load_hit", 32'(busBusy), 0);
        busEnable = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] a;
        rst = 1'b1; enable = 1'b1; writeEnable = 1'b1; invalidateAll = 1'b0;
        busEnable = 1'b0; busWriteEnable = 1'b0; busVirtualAddress = '0;
        fill_done = 1'b0; fill_error = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_fill_request", 32'(fill_request), 0);
        check("rst_valid", 32'(pageValid), 0);
        check("rst_dirty", 32'(pageDirty), 0);
        check("rst_bus_error", 32'(busError), 0);
        check("rst_fill_cmd", 32'({fill_write, fill_pageNumber, fill_pageIndex}), 0);

        // First miss and load into slot 0
        busVirtualAddress = 24'h000104; busEnable = 1'b1;
        #1;
        check("miss_busy", 32'(busBusy), 1);
        check("miss_no_req_yet", 32'(fill_request), 0);
        tick();
        check("load_req", 32'({fill_request, fill_write, fill_pageNumber, fill_pageIndex}),
              32'({1'b1, 1'b0, 17'h00002, 3'd0}));
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        check("load_valid", 32'(pageValid), 32'h01);
        check("load_busy", 32'(busBusy), 0);
        check("load_phys", 32'(busPhysicalAddress), 32'h01);

        // Hit write permitted, then refused
        busVirtualAddress = 24'h000108; busWriteEnable = 1'b1;
        #1;
        check("wr_ok_error", 32'(busError), 0);
        tick();
        check("wr_dirty", 32'(pageDirty), 32'h01);
        writeEnable = 1'b0;
        #1;
        check("wr_protect_error", 32'(busError), 1);
        tick();
        check("wr_protect_dirty", 32'(pageDirty), 32'h01);
        writeEnable = 1'b1; busEnable = 1'b0; busWriteEnable = 1'b0;
        tick();

        // Fill all slots, then evict dirty slot 0
        for (int p = 3; p <= 9; p++) load_page(17'(p));
        check("full_valid", 32'(pageValid), 32'hFF);
        busVirtualAddress = 24'h000500; busEnable = 1'b1;
        tick();
        check("flush_req", 32'({fill_request, fill_write, fill_pageNumber, fill_pageIndex}),
              32'({1'b1, 1'b1, 17'h00002, 3'd0}));
        check("flush_valid_cleared", 32'(pageValid), 32'hFE);
        serve(1'b0, 1'b1);
        check("reload_req", 32'({fill_request, fill_write, fill_pageNumber, fill_pageIndex}),
              32'({1'b1, 1'b0, 17'h0000A, 3'd0}));
        check("flush_dirty_cleared", 32'(pageDirty), 32'h00);
        serve(1'b0, 1'b1);
        check("reload_phys", 32'(busPhysicalAddress), 32'h00);
        check("reload_valid", 32'(pageValid), 32'hFF);
        busEnable = 1'b0;
        tick();
        busVirtualAddress = {17'h0000B, 7'h00}; busEnable = 1'b1;
        tick();
        check("rr_pointer_1", 32'({fill_write, fill_pageIndex}), 32'({1'b0, 3'd1}));
        serve(1'b0, 1'b1);
        busEnable = 1'b0;
        tick();

        // Load error, then automatic retry
        busVirtualAddress = {17'h0000C, 7'h00}; busEnable = 1'b1;
        tick();
        check("err_load_idx", 32'(fill_pageIndex), 2);
        fill_error = 1'b1;
        tick();
        fill_error = 1'b0;
        check("err_pulse", 32'(busError), 1);
        check("err_valid", 32'(pageValid), 32'hFB);
        check("err_req_drop", 32'(fill_request), 0);
        tick();
        check("err_pulse_end", 32'(busError), 0);
        check("err_retry", 32'({fill_request, fill_pageIndex}), 32'({1'b1, 3'd2}));
        serve(1'b0, 1'b1);
        check("err_retry_valid", 32'(pageValid), 32'hFF);
        busEnable = 1'b0;
        tick();

        // Done and error together count as error
        busVirtualAddress = {17'h0000D, 7'h00}; busEnable = 1'b1;
        tick();
        serve(1'b1, 1'b1);
        check("both_valid", 32'(pageValid), 32'hF7);
        check("both_error", 32'(busError), 1);
        tick();
        check("both_retry", 32'({fill_request, fill_pageIndex}), 32'({1'b1, 3'd3}));
        serve(1'b0, 1'b1);
        busEnable = 1'b0;
        tick();

        // invalidateAll ignored mid-flush, honoured in idle
        busVirtualAddress = 24'h000300; busEnable = 1'b1; busWriteEnable = 1'b1;
        tick();
        busEnable = 1'b0; busWriteEnable = 1'b0;
        check("slot4_dirty", 32'(pageDirty), 32'h10);
        tick();
        busVirtualAddress = {17'h0000E, 7'h00}; busEnable = 1'b1;
        tick();
        check("flush4_req", 32'({fill_write, fill_pageNumber, fill_pageIndex}),
              32'({1'b1, 17'h00006, 3'd4}));
        invalidateAll = 1'b1;
        tick();
        invalidateAll = 1'b0;
        check("inv_ignored_valid", 32'(pageValid), 32'hEF);
        check("inv_ignored_dirty", 32'(pageDirty), 32'h10);
        check("inv_ignored_req", 32'({fill_request, fill_write}), 32'h3);
        serve(1'b0, 1'b1);
        serve(1'b0, 1'b1);
        check("flush4_done_valid", 32'(pageValid), 32'hFF);
        busEnable = 1'b0;
        invalidateAll = 1'b1;
        tick();
        invalidateAll = 1'b0;
        check("inv_valid", 32'(pageValid), 32'h00);
        check("inv_dirty", 32'(pageDirty), 32'h00);

        // Asynchronous reset in the middle of a load
        load_page(17'h00002);
        busVirtualAddress = {17'h00003, 7'h00}; busEnable = 1'b1;
        tick();
        check("pre_rst_req", 32'({fill_request, pageValid}), 32'({1'b1, 8'h01}));
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(fill_request), 0);
        check("async_rst_valid", 32'(pageValid), 0);
        busEnable = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Randomized run against the reference model
        for (int i = 0; i < 8; i++) tag_m[i] = '0;
        valid_m = '0; dirty_m = '0; ptr_m = 0;
        sb_on = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                invalidateAll = 1'b1;
                tick();
                invalidateAll = 1'b0;
                valid_m = '0; dirty_m = '0; ptr_m = 0;
            end else begin
                bit en, we, wen;
                a   = {17'($urandom_range(0, 11)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                en  = ($urandom_range(0, 15) != 0);
                we  = $urandom_range(0, 1) != 0;
                wen = ($urandom_range(0, 3) != 0);
                model_access(a, en, we, wen);
                drive_access(a, en, we, wen);
            end
        end
        tick();
        check("fill_q_drained", 32'(fill_q.size()), 0);
        check("resp_q_drained", 32'(resp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
